seq_det_sched: RTL and testbench

Time-multiplexed scheduler that shares one overlapping "1101" Mealy detector core among `N_CH` serial bit channels. Each channel keeps its own 2-bit detector state. A round-robin arbiter picks at most one pending bit per cycle, advances that channel's state, and reports matches tagged with the channel index. The block sits between the per-lane bit sources and the match-event consumer, replacing one detector instance per lane.

---
 rtl/seq_det_sched.sv | 148 ++++++++++++++
 tb/tb_seq_det_sched.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_det_sched                                                   |
// | Purpose  : Shares one overlapping "1101" Mealy detector among N_CH serial  |
// |            bit channels. Each channel keeps its own 2-bit state, and a     |
// |            round-robin arbiter consumes at most one pending bit per cycle. |
// |            Matches are reported as a registered pulse tagged with the      |
// |            channel index, plus a saturating total-match counter.           |
// | Ports    : clk          - clock, rising edge                               |
// |            rst          - asynchronous reset, active low                   |
// |            req[N]       - channel i has a bit pending on din[i]            |
// |            din[N]       - serial bit of channel i                          |
// |            clr_ch[N]    - synchronous clear of channel i state             |
// |            gnt[N]       - one-hot/zero grant (combinational)               |
// |            match        - one-cycle pulse on a detected "1101"             |
// |            match_ch     - channel index of the last match                  |
// |            match_count  - saturating count of matches since reset          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_det_sched #(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 8,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  din,
  input  logic [N_CH-1:0]  clr_ch,
  output logic [N_CH-1:0]  gnt,
  output logic             match,
  output logic [CH_W-1:0]  match_ch,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic [1:0] {
    S0 = 2'd0,  // idle
    S1 = 2'd1,  // seen "1"
    S2 = 2'd2,  // seen "11"
    S3 = 2'd3   // seen "110"
  } det_state_t;

  det_state_t       st_q [N_CH];
  det_state_t       st_d [N_CH];
  logic [CH_W-1:0]  last_q, last_d;
  logic             match_q, match_d;
  logic [CH_W-1:0]  match_ch_q, match_ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_CH-1:0]  elig;
  logic [N_CH-1:0]  gnt_w;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_any;
  int               arb_t;
  logic [CH_W-1:0]  arb_idx;

  // Shared detector core: next state for one consumed bit.
  function automatic det_state_t det_next(input det_state_t s, input logic b);
    det_state_t n;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S2 : S0;
      S2:      n = b ? S2 : S3;
      S3:      n = b ? S1 : S0;  // S3 + 1 is the match; keep the trailing "1"
      default: n = S0;
    endcase
    return n;
  endfunction

  // Channels under clear are masked so their pending bit survives the clear.
  // Gating with rst keeps gnt low while reset is held.
  assign elig = req & ~clr_ch & {N_CH{rst}};

  // Round-robin search starting just after the last granted index.
  always_comb begin
    gnt_w   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    arb_t   = 0;
    arb_idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      arb_t = int'(last_q) + k;
      if (arb_t >= N_CH) begin
        arb_t = arb_t - N_CH;
      end
      arb_idx = CH_W'(arb_t);
      if (!gnt_any && elig[arb_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_idx;
      end
    end
    if (gnt_any) begin
      gnt_w = N_CH'(1) << gnt_idx;
    end
  end

  always_comb begin
    last_d     = last_q;
    match_d    = 1'b0;
    match_ch_d = match_ch_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i] = st_q[i];
      if (clr_ch[i]) begin
        st_d[i] = S0;
      end else if (gnt_w[i]) begin
        st_d[i] = det_next(st_q[i], din[i]);
      end
    end
    if (gnt_any) begin
      last_d = gnt_idx;
      if (st_q[gnt_idx] == S3 && din[gnt_idx]) begin
        match_d    = 1'b1;
        match_ch_d = gnt_idx;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i] <= S0;
      end
      last_q     <= CH_W'(N_CH - 1);  // channel 0 wins the first search
      match_q    <= 1'b0;
      match_ch_q <= '0;
      cnt_q      <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i] <= st_d[i];
      end
      last_q     <= last_d;
      match_q    <= match_d;
      match_ch_q <= match_ch_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt         = gnt_w;
  assign match       = match_q;
  assign match_ch    = match_ch_q;
  assign match_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_det_sched                                                |
// | Purpose  : Directed self-checking bench for seq_det_sched. A second        |
// |            instance with a 2-bit counter shares the stimulus so counter    |
// |            saturation can be observed.                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] din = '0;
  logic [3:0] clr_ch = '0;

  logic [3:0] gnt;
  logic       match;
  logic [1:0] match_ch;
  logic [7:0] match_count;

  logic [3:0] gnt_s;
  logic       match_s;
  logic [1:0] match_ch_s;
  logic [1:0] match_count_s;

  int total = 0;
  int bad   = 0;

  seq_det_sched #(.N_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .clr_ch(clr_ch),
    .gnt(gnt), .match(match), .match_ch(match_ch), .match_count(match_count)
  );

  seq_det_sched #(.N_CH(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .req(req), .din(din), .clr_ch(clr_ch),
    .gnt(gnt_s), .match(match_s), .match_ch(match_ch_s), .match_count(match_count_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle (called at posedge+1), check gnt mid-cycle and the
  // registered match outputs just after the edge.
  task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] d,
                     input logic [3:0] c, input logic [3:0] eg,
                     input logic em, input logic [1:0] emc);
    req = r; din = d; clr_ch = c;
    @(negedge clk);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    @(posedge clk); #1;
    chk({tag, ".match"}, 32'(match), 32'(em));
    if (em) chk({tag, ".ch"}, 32'(match_ch), 32'(emc));
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; din = '0; clr_ch = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  bit         t1b [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  bit         t1m [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] t3r [8] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h8};
  logic [3:0] t3d [8] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'h0, 4'h0, 4'hA, 4'h8};
  logic [3:0] t3g [8] = '{4'h2, 4'h8, 4'h2, 4'h8, 4'h2, 4'h8, 4'h2, 4'h8};
  bit         t3m [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] t3c [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3};

  initial begin
    // Reset state, with requests present to show gnt is held low.
    req = 4'hF;
    #2;
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.match", 32'(match), 32'h0);
    chk("rst.ch", 32'(match_ch), 32'h0);
    chk("rst.cnt", 32'(match_count), 32'h0);
    req = '0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Channel 0 alone: 1,1,0,1,1,0,1 -> matches after bits 4 and 7.
    for (int i = 0; i < 7; i++)
      cyc("t1", 4'b0001, {3'b000, t1b[i]}, 4'b0000, 4'b0001, t1m[i], 2'd0);
    chk("t1.cnt", 32'(match_count), 32'd2);

    // All channels requesting with zero data: strict rotation, no match.
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc("t2", 4'hF, 4'h0, 4'h0, 4'(1 << (i % 4)), 1'b0, 2'd0);
    chk("t2.cnt", 32'(match_count), 32'd0);

    // Channels 1 and 3 interleave 1,1,0,1.
    for (int i = 0; i < 8; i++)
      cyc("t3", t3r[i], t3d[i], 4'h0, t3g[i], t3m[i], t3c[i]);
    chk("t3.cnt", 32'(match_count), 32'd2);
    chk("t3.cnt_s", 32'(match_count_s), 32'd2);

    // Channel 2: 1,1,0 then clear (masked), then 1 lands in S1; 1,0,1 matches.
    cyc("t4a", 4'h4, 4'h4, 4'h0, 4'h4, 1'b0, 2'd0);
    cyc("t4b", 4'h4, 4'h4, 4'h0, 4'h4, 1'b0, 2'd0);
    cyc("t4c", 4'h4, 4'h0, 4'h0, 4'h4, 1'b0, 2'd0);
    cyc("t4clr", 4'h4, 4'h4, 4'h4, 4'h0, 1'b0, 2'd0);
    cyc("t4d", 4'h4, 4'h4, 4'h0, 4'h4, 1'b0, 2'd0);
    cyc("t4e", 4'h4, 4'h4, 4'h0, 4'h4, 1'b0, 2'd0);
    cyc("t4f", 4'h4, 4'h0, 4'h0, 4'h4, 1'b0, 2'd0);
    cyc("t4g", 4'h4, 4'h4, 4'h0, 4'h4, 1'b1, 2'd2);
    chk("t4.cnt", 32'(match_count), 32'd3);
    chk("t4.cnt_s", 32'(match_count_s), 32'd3);

    // Channel 0 to S3, then asynchronous reset between edges.
    cyc("t6a", 4'h1, 4'h1, 4'h0, 4'h1, 1'b0, 2'd0);
    cyc("t6b", 4'h1, 4'h1, 4'h0, 4'h1, 1'b0, 2'd0);
    cyc("t6c", 4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 2'd0);
    #2;
    rst = 1'b0;
    req = 4'h1;
    #1;
    chk("t6.gnt", 32'(gnt), 32'h0);
    chk("t6.match", 32'(match), 32'h0);
    chk("t6.ch", 32'(match_ch), 32'h0);
    chk("t6.cnt", 32'(match_count), 32'h0);
    chk("t6.cnt_s", 32'(match_count_s), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc("t6d", 4'h1, 4'h1, 4'h0, 4'h1, 1'b0, 2'd0);
    cyc("t6e", 4'h1, 4'h1, 4'h0, 4'h1, 1'b0, 2'd0);
    cyc("t6f", 4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 2'd0);
    cyc("t6g", 4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 2'd0);

    // Five overlapping matches on channel 0; 2-bit counter saturates at 3.
    do_reset();
    begin
      int m;
      m = 0;
      for (int i = 0; i < 16; i++) begin
        cyc("t5", 4'h1, {3'b000, (i % 3) != 2}, 4'h0, 4'h1,
            (i >= 3) && (i % 3 == 0), 2'd0);
        if ((i >= 3) && (i % 3 == 0)) begin
          m++;
          chk("t5.cnt_s", 32'(match_count_s), 32'((m > 3) ? 3 : m));
        end
      end
    end
    chk("t5.cnt", 32'(match_count), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
